jt51_op_seq: RTL and testbench
==============================

# jt51_op_seq

Slot sequencer and connection controller for the JT51 operator pipeline. It owns the 32-slot operator time-multiplex counter and an 8-entry per-channel register file holding connection (ALG) and feedback (FB) settings. Every operator-enable cycle it drives the slot-entry strobes and modulation-source selects that the operator datapath needs for the slot entering it. It sits between the host register interface and the operator datapath.

## Interface
- No parameters.
- clk  in  1  system clock
- rst_n  in  1  asynchronous reset, active-low
- cen  in  1  clock enable; all state advances only when high
- cfg_we  in  1  write strobe for the channel register file
- cfg_ch  in  3  channel written
- cfg_din  in  6  {fb[2:0], con[2:0]}
- slot  out  5  slot entering the operator this cycle; {group[1:0], ch[2:0]}
- zero  out  1  high while slot==0
- m1_enters, m2_enters, c1_enters, c2_enters  out  1 each  group strobe (group 0/1/2/3)
- use_prevprev1, use_prev1, use_prev2, use_internal_x, use_internal_y  out  1 each  modulation-source selects for the entering slot
- con_I  out  3  connection of the entering slot's channel
- fb_II  out  3  feedback of the channel that entered one cen earlier

## Operation
- Counter: 5-bit `cnt` increments by 1 per cen and wraps 31→0. `slot` = `cnt`. Group = `cnt[4:3]`: 0=M1, 1=M2, 2=C1, 3=C2. Channel = `cnt[2:0]`.
- Register file: 8×6 bits. A write occurs on `cfg_we` and is gated by cen. Unwritten entries hold 0.
- Outputs are registered and describe the slot whose `cnt` value is presented this cycle.
- Selects are decoded from group and `con` = con_I. Unlisted selects are 0.
  - M1: use_prevprev1=1 and use_prev1=1 for every alg (self-feedback pair).
  - M2: use_prev1=1 for alg∈{0,1,2}; use_prevprev1=1 for alg∈{1,5}.
  - C1: use_prev2=1 for alg∈{0,3,4,5,6}.
  - C2: use_prev2=1 for alg∈{0,1,2,3,4}; use_prev1=1 for alg 2; use_internal_y=1 for alg 3; use_prevprev1=1 for alg 5.
  - Alg 7 C1/M2/C2: all selects 0.
  - use_internal_x is always 0; it is kept for port compatibility.
- Exactly one of the four `*_enters` strobes is high each cycle after reset has released and the first cen has occurred.
- fb_II is a registered copy of the entering channel's fb, delayed one cen, so it aligns with the datapath's second stage.
- Write bypass: when cfg_we targets the channel whose entry is being read on the same cen, con_I/selects use the new cfg_din value, and so does the fb value captured for fb_II.

## Timing
- Reset (rst_n low, asynchronous):
  - cnt=0 and the register file is cleared.
  - All outputs are 0, including `zero` and all strobes.
- First cen after release: outputs present slot 0 (zero=1, m1_enters=1, M1 selects).
- Latency:
  - cfg write to outputs: visible at the next occurrence of that channel's slot, or the same cycle if bypassed.
  - fb_II lags con_I by exactly one cen.
- cen low: counter, register file and all outputs hold. A write presented while cen is low is ignored.
- Reset asserted mid-frame: immediate return to the reset state. The frame restarts at slot 0, with no partial-slot outputs.
- Wrap: slot 31 (C2, ch7) is followed by slot 0 with no gap cycle. `zero` is high for one cen per 32.

## Test plan
- Reset then 64 cen pulses → slot sequence 0..31,0..31. zero is high at slot 0 only. m1_enters is high for slots 0–7 and c1_enters for slots 16–23.
- Write ch3 con=5 fb=6, run one frame → at slot 11 (M2, ch3): use_prevprev1=1, use_prev1=0. At slot 27 (C2): use_prevprev1=1. fb_II=6 one cen after slot 3.
- Write con=3 to ch0 exactly when slot=24 (C2, ch0) → same-cycle outputs: con_I=3, use_prev2=1, use_internal_y=1.
- Sweep con 0..7 on ch5 → all four slots of ch5 match the select table above. Alg 7 gives zero selects on M2/C1/C2.
- cen held low for 10 clk with cfg_we high → slot, outputs and register file are unchanged.
- rst_n pulsed low at slot 19 (async, between clock edges) → outputs go to 0 immediately. After release, the first cen shows slot 0 and the register file reads con=0.

Source files
------------

// File: rtl/jt51_op_seq_if.sv
// Bundles the host configuration bus and the operator-facing outputs of
// jt51_op_seq. Signal names match the original flat port list.
//   master : host / testbench side (drives cfg_*, observes sequencer outputs)
//   slave  : sequencer side (receives cfg_*, drives slot/strobes/selects)
interface jt51_op_seq_if;
  logic       cfg_we;
  logic [2:0] cfg_ch;
  logic [5:0] cfg_din;        // {fb[2:0], con[2:0]}
  logic [4:0] slot;
  logic       zero;
  logic       m1_enters;
  logic       m2_enters;
  logic       c1_enters;
  logic       c2_enters;
  logic       use_prevprev1;
  logic       use_prev1;
  logic       use_prev2;
  logic       use_internal_x;
  logic       use_internal_y;
  logic [2:0] con_I;
  logic [2:0] fb_II;

  modport master (
    output cfg_we, cfg_ch, cfg_din,
    input  slot, zero, m1_enters, m2_enters, c1_enters, c2_enters,
           use_prevprev1, use_prev1, use_prev2, use_internal_x,
           use_internal_y, con_I, fb_II
  );

  modport slave (
    input  cfg_we, cfg_ch, cfg_din,
    output slot, zero, m1_enters, m2_enters, c1_enters, c2_enters,
           use_prevprev1, use_prev1, use_prev2, use_internal_x,
           use_internal_y, con_I, fb_II
  );
endinterface

// File: rtl/jt51_op_seq.sv
// JT51 operator slot sequencer and connection controller.
// Runs the 32-slot time-multiplex counter ({group, ch}) and an 8-entry
// per-channel {fb, con} register file, and on every cen registers the
// slot-entry strobes and modulation-source selects for the slot entering
// the operator datapath.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset (counter, register file, outputs -> 0)
//   cen    clock enable; nothing advances while low (writes included)
//   bus    jt51_op_seq_if.slave: cfg_we/cfg_ch/cfg_din in; slot, zero,
//          *_enters, use_* selects, con_I, fb_II out
module jt51_op_seq (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cen,
  jt51_op_seq_if.slave   bus
);

  logic [4:0] cnt;
  logic [5:0] regs [8];
  logic [2:0] fb_I;

  logic [1:0] grp;
  logic [2:0] ch;
  logic [5:0] rd;
  logic [2:0] alg;
  logic       n_pp1, n_p1, n_p2, n_iy;

  assign grp = cnt[4:3];
  assign ch  = cnt[2:0];

  // A write to the channel being read on this cen bypasses the array so the
  // entering slot already sees the new settings.
  always_comb begin
    rd = regs[ch];
    if (bus.cfg_we && (bus.cfg_ch == ch))
      rd = bus.cfg_din;
  end

  assign alg = rd[2:0];

  always_comb begin
    n_pp1 = 1'b0;
    n_p1  = 1'b0;
    n_p2  = 1'b0;
    n_iy  = 1'b0;
    unique case (grp)
      2'd0: begin                               // M1: self-feedback pair
        n_pp1 = 1'b1;
        n_p1  = 1'b1;
      end
      2'd1: begin                               // M2
        n_p1  = (alg inside {3'd0, 3'd1, 3'd2});
        n_pp1 = (alg inside {3'd1, 3'd5});
      end
      2'd2: begin                               // C1
        n_p2  = (alg inside {3'd0, 3'd3, 3'd4, 3'd5, 3'd6});
      end
      default: begin                            // C2
        n_p2  = (alg inside {3'd0, 3'd1, 3'd2, 3'd3, 3'd4});
        n_p1  = (alg == 3'd2);
        n_iy  = (alg == 3'd3);
        n_pp1 = (alg == 3'd5);
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      for (int unsigned i = 0; i < 8; i++)
        regs[i] <= '0;
      fb_I               <= '0;
      bus.slot           <= '0;
      bus.zero           <= 1'b0;
      bus.m1_enters      <= 1'b0;
      bus.m2_enters      <= 1'b0;
      bus.c1_enters      <= 1'b0;
      bus.c2_enters      <= 1'b0;
      bus.use_prevprev1  <= 1'b0;
      bus.use_prev1      <= 1'b0;
      bus.use_prev2      <= 1'b0;
      bus.use_internal_x <= 1'b0;
      bus.use_internal_y <= 1'b0;
      bus.con_I          <= '0;
      bus.fb_II          <= '0;
    end else if (cen) begin
      cnt <= cnt + 5'd1;
      if (bus.cfg_we)
        regs[bus.cfg_ch] <= bus.cfg_din;
      bus.slot           <= cnt;
      bus.zero           <= (cnt == 5'd0);
      bus.m1_enters      <= (grp == 2'd0);
      bus.m2_enters      <= (grp == 2'd1);
      bus.c1_enters      <= (grp == 2'd2);
      bus.c2_enters      <= (grp == 2'd3);
      bus.use_prevprev1  <= n_pp1;
      bus.use_prev1      <= n_p1;
      bus.use_prev2      <= n_p2;
      bus.use_internal_x <= 1'b0;
      bus.use_internal_y <= n_iy;
      bus.con_I          <= alg;
      // fb is captured alongside con_I, then delayed one more cen.
      fb_I               <= rd[5:3];
      bus.fb_II          <= fb_I;
    end
  end

endmodule

// File: tb/tb_jt51_op_seq.sv
module tb_jt51_op_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cen = 1'b0;
  int tests = 0;
  int fails = 0;

  jt51_op_seq_if bus ();

  jt51_op_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .cen   (cen),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Hand-written select table, {pp1, p1, p2, ix, iy}, index = alg.
  logic [4:0] exp_m2 [8] = '{5'b01000, 5'b11000, 5'b01000, 5'b00000,
                             5'b00000, 5'b10000, 5'b00000, 5'b00000};
  logic [4:0] exp_c1 [8] = '{5'b00100, 5'b00000, 5'b00000, 5'b00100,
                             5'b00100, 5'b00100, 5'b00100, 5'b00000};
  logic [4:0] exp_c2 [8] = '{5'b00100, 5'b00100, 5'b01100, 5'b00101,
                             5'b00100, 5'b10000, 5'b00000, 5'b00000};

  function automatic logic [4:0] sels();
    return {bus.use_prevprev1, bus.use_prev1, bus.use_prev2,
            bus.use_internal_x, bus.use_internal_y};
  endfunction

  function automatic logic [3:0] strobes();
    return {bus.c2_enters, bus.c1_enters, bus.m2_enters, bus.m1_enters};
  endfunction

  task automatic tick();
    @(negedge clk);
    cen = 1'b1;
    @(posedge clk);
    #1;
    cen = 1'b0;
  endtask

  // Advance until the given slot is presented; a missed bound is a failure.
  task automatic run_to(input logic [4:0] target);
    int n = 0;
    while (bus.slot !== target && n < 40) begin
      tick();
      n++;
    end
    tests++;
    if (bus.slot !== target) begin
      fails++;
      $display("FAIL run_to: slot=%0d required=%0d", bus.slot, target);
    end
  endtask

  task automatic test_reset();
    tests++;
    if ({bus.slot, bus.zero, strobes(), sels(), bus.con_I, bus.fb_II} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: slot=%0d zero=%b strb=%b sel=%b con=%0d fb=%0d required all 0",
               bus.slot, bus.zero, strobes(), sels(), bus.con_I, bus.fb_II);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_sequence();
    logic [3:0] es;
    for (int i = 0; i < 64; i++) begin
      tick();
      es = 4'b0001 << (i % 32) / 8;
      tests++;
      if (bus.slot !== 5'(i % 32)) begin
        fails++;
        $display("FAIL seq_slot: i=%0d slot=%0d required=%0d", i, bus.slot, i % 32);
      end
      tests++;
      if (bus.zero !== ((i % 32) == 0)) begin
        fails++;
        $display("FAIL seq_zero: i=%0d zero=%b required=%b", i, bus.zero, (i % 32) == 0);
      end
      tests++;
      if (strobes() !== es) begin
        fails++;
        $display("FAIL seq_strobes: i=%0d strb=%b required=%b", i, strobes(), es);
      end
    end
  endtask

  task automatic test_write_ch3();
    // Write happens while slot 0 enters, so no bypass involved.
    bus.cfg_we = 1'b1; bus.cfg_ch = 3'd3; bus.cfg_din = {3'd6, 3'd5};
    tick();
    bus.cfg_we = 1'b0;
    for (int i = 1; i < 32; i++) begin
      tick();
      if (bus.slot == 5'd3) begin
        tests++;
        if (bus.con_I !== 3'd5) begin
          fails++; $display("FAIL ch3_con: con_I=%0d required=5", bus.con_I);
        end
      end
      if (bus.slot == 5'd4) begin
        tests++;
        if (bus.fb_II !== 3'd6) begin
          fails++; $display("FAIL ch3_fb_II: fb_II=%0d required=6", bus.fb_II);
        end
      end
      if (bus.slot == 5'd11) begin
        tests++;
        if ({bus.use_prevprev1, bus.use_prev1} !== 2'b10) begin
          fails++; $display("FAIL ch3_m2: pp1,p1=%b required=10",
                            {bus.use_prevprev1, bus.use_prev1});
        end
      end
      if (bus.slot == 5'd27) begin
        tests++;
        if (bus.use_prevprev1 !== 1'b1) begin
          fails++; $display("FAIL ch3_c2: pp1=%b required=1", bus.use_prevprev1);
        end
      end
    end
  endtask

  task automatic test_bypass();
    run_to(5'd23);
    bus.cfg_we = 1'b1; bus.cfg_ch = 3'd0; bus.cfg_din = {3'd0, 3'd3};
    tick();
    bus.cfg_we = 1'b0;
    tests++;
    if ({bus.slot, bus.con_I, bus.use_prev2, bus.use_internal_y, bus.c2_enters}
        !== {5'd24, 3'd3, 1'b1, 1'b1, 1'b1}) begin
      fails++;
      $display("FAIL bypass: slot=%0d con=%0d p2=%b iy=%b c2=%b required 24,3,1,1,1",
               bus.slot, bus.con_I, bus.use_prev2, bus.use_internal_y, bus.c2_enters);
    end
  endtask

  task automatic test_sweep_ch5();
    logic [4:0] ex;
    for (int a = 0; a < 8; a++) begin
      bus.cfg_we = 1'b1; bus.cfg_ch = 3'd5; bus.cfg_din = {3'd0, 3'(a)};
      tick();
      bus.cfg_we = 1'b0;
      for (int k = 0; k < 32; k++) begin
        tick();
        if (bus.slot[2:0] == 3'd5) begin
          case (bus.slot[4:3])
            2'd0:    ex = 5'b11000;
            2'd1:    ex = exp_m2[a];
            2'd2:    ex = exp_c1[a];
            default: ex = exp_c2[a];
          endcase
          tests++;
          if (sels() !== ex || bus.con_I !== 3'(a)) begin
            fails++;
            $display("FAIL sweep: alg=%0d slot=%0d sel=%b con=%0d required sel=%b con=%0d",
                     a, bus.slot, sels(), bus.con_I, ex, a);
          end
        end
      end
    end
  endtask

  task automatic test_cen_hold();
    logic [4:0] s0;
    logic [3:0] st0;
    logic [4:0] se0;
    logic [2:0] c0;
    s0 = bus.slot; st0 = strobes(); se0 = sels(); c0 = bus.con_I;
    bus.cfg_we = 1'b1; bus.cfg_ch = 3'd0; bus.cfg_din = 6'h3f;
    repeat (10) @(posedge clk);
    #1;
    bus.cfg_we = 1'b0;
    tests++;
    if ({bus.slot, strobes(), sels(), bus.con_I} !== {s0, st0, se0, c0}) begin
      fails++;
      $display("FAIL cen_hold: slot=%0d strb=%b sel=%b con=%0d required %0d %b %b %0d",
               bus.slot, strobes(), sels(), bus.con_I, s0, st0, se0, c0);
    end
    run_to(5'd0);
    tests++;
    if (bus.con_I !== 3'd3) begin
      fails++; $display("FAIL cen_hold_regfile: con_I=%0d required=3", bus.con_I);
    end
  endtask

  task automatic test_reset_mid();
    run_to(5'd19);
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({bus.slot, bus.zero, strobes(), sels(), bus.con_I} !== '0) begin
      fails++;
      $display("FAIL reset_mid: slot=%0d zero=%b strb=%b sel=%b con=%0d required all 0",
               bus.slot, bus.zero, strobes(), sels(), bus.con_I);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tests++;
    if ({bus.slot, bus.zero, bus.m1_enters, bus.con_I} !== {5'd0, 1'b1, 1'b1, 3'd0}) begin
      fails++;
      $display("FAIL reset_restart: slot=%0d zero=%b m1=%b con=%0d required 0,1,1,0",
               bus.slot, bus.zero, bus.m1_enters, bus.con_I);
    end
  endtask

  initial begin
    bus.cfg_we = 1'b0; bus.cfg_ch = '0; bus.cfg_din = '0;
    #12;
    test_reset();
    test_sequence();
    test_write_ch3();
    test_bypass();
    test_sweep_ch5();
    test_cen_hold();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
